// File: rtl/wc_pkg.sv
// Shared constants, FSM state type and tile-count helper for the F(2,5)
// Winograd tile scheduler.
package wc_pkg;

  localparam int WC_DW     = 10;
  localparam int WC_TIN    = 6;
  localparam int WC_TOUT   = 2;
  localparam int WC_STRIDE = 2;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wc_state_e;

  // Number of overlapping stride-2 windows that fit in one row.
  function automatic int tiles_per_row(input int len);
    return (len - WC_TIN) / WC_STRIDE + 1;
  endfunction

endpackage

// File: rtl/wc_win_sreg.sv
// Sample window for the Winograd core: N samples of DW bits, shifted in at
// the LSB field so the oldest sample sits in the MSB field.
module wc_win_sreg
  import wc_pkg::*;
#(
  parameter int DW = WC_DW,
  parameter int N  = WC_TIN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            shift_en,
  input  logic [DW-1:0]   din,
  output logic [N*DW-1:0] win
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= '0;
    end else if (shift_en) begin
      win <= {win[(N-1)*DW-1:0], din};
    end
  end

endmodule

// File: rtl/wc_tile_seq.sv
// Tile scheduler for the wc core: builds stride-2 windows from a sample
// stream, holds them for the core latency and hands results downstream.
module wc_tile_seq
  import wc_pkg::*;
#(
  parameter int DW       = WC_DW,
  parameter int LEN      = 16,
  parameter int CORE_LAT = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic [WC_TIN*DW-1:0]   core_d,
  input  logic [WC_TOUT*DW-1:0]  core_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WC_TOUT*DW-1:0]  out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int TILES = tiles_per_row(LEN);
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int LW    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  wc_state_e       state, state_nxt;
  logic [TW-1:0]   tile_idx;
  logic [2:0]      fill_cnt;
  logic [2:0]      need;
  logic [LW-1:0]   lat_cnt;
  logic            accept;
  logic            fill_done;
  logic            lat_done;
  logic            out_hs;

  assign in_ready  = (state == FILL);
  assign busy      = (state != FILL);
  assign accept    = in_ready && in_valid;
  assign fill_done = accept && ((fill_cnt + 3'd1) == need);
  assign lat_done  = (state == RUN) && (lat_cnt == LW'(CORE_LAT - 1));
  assign out_hs    = (state == DRAIN) && out_valid && out_ready;

  wc_win_sreg #(
    .DW (DW),
    .N  (WC_TIN)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (in_data),
    .win      (core_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (fill_done) state_nxt = RUN;
      RUN:     if (lat_done)  state_nxt = DRAIN;
      DRAIN:   if (out_hs)    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // A new row needs a full window; later tiles of the same row reuse four
  // samples, so only the stride's worth of new samples is awaited.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt  <= '0;
      need      <= 3'(WC_TIN);
      lat_cnt   <= '0;
      tile_idx  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (fill_done) begin
        fill_cnt <= '0;
        lat_cnt  <= '0;
      end else if (accept) begin
        fill_cnt <= fill_cnt + 3'd1;
      end

      if ((state == RUN) && !lat_done) begin
        lat_cnt <= lat_cnt + LW'(1);
      end

      if (lat_done) begin
        out_data  <= core_z;
        out_valid <= 1'b1;
        out_last  <= (tile_idx == TW'(TILES - 1));
      end

      if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (out_last) begin
          tile_idx <= '0;
          need     <= 3'(WC_TIN);
        end else begin
          tile_idx <= tile_idx + TW'(1);
          need     <= 3'(WC_STRIDE);
        end
      end
    end
  end

endmodule
